sram_model: RTL

Parametrised behavioural SRAM stand-in for the bcrypt datapath, replacing the fixed 8-bit-wordline / 64-bit-bitline dummy. It has real storage, byte-masked writes, a configurable-latency response pipeline with backpressure, and out-of-range detection. It sits between the S-box/P-array controllers and the eventual hard macro, and has the same request/response behaviour the macro wrapper will present.

---
 rtl/sram_model.sv | 115 +++++++++++
 1 files changed

// File: rtl/sram_model.sv
// Behavioural SRAM stand-in: DEPTH x DATA_W storage with byte-masked writes,
// out-of-range flagging and a LATENCY-deep response pipeline with backpressure.
module sram_model #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic [DATA_W/8-1:0]   req_wmask_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_we_o,
  output logic                  rsp_err_o,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  busy_o,
  output logic [LATENCY-1:0]    dbg_stage_valid_o
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  // Handshake: a request is taken at a posedge when req_valid_i && req_ready_o;
  // a response leaves at a posedge when rsp_valid_o && rsp_ready_i. Everything
  // shifts together, so req_ready_o is the pipeline's advance enable.

  logic                 advance;
  logic                 accept;
  logic                 in_range;
  logic                 wr_en;
  logic [IDX_W-1:0]     idx;

  logic [DATA_W-1:0]    mem_q [DEPTH];

  logic [LATENCY-1:0]   vld_q, vld_d;
  logic [LATENCY-1:0]   we_q, we_d;
  logic [LATENCY-1:0]   err_q, err_d;
  logic [DATA_W-1:0]    data_q [LATENCY];
  logic [DATA_W-1:0]    data_d [LATENCY];
  logic [DATA_W-1:0]    s0_data;

  assign idx      = req_addr_i[IDX_W-1:0];
  assign in_range = {1'b0, req_addr_i} < DEPTH_V;
  assign advance  = !(vld_q[LATENCY-1] && !rsp_ready_i);
  assign accept   = req_valid_i && advance;
  assign wr_en    = accept && req_we_i && in_range;

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (req_wmask_i[b]) begin
          mem_q[idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Read data is captured at acceptance, so later writes cannot alter it.
  always_comb begin
    s0_data = '0;
    if (accept && !req_we_i) begin
      s0_data = in_range ? mem_q[idx] : '1;
    end
  end

  always_comb begin
    vld_d     = vld_q;
    we_d      = we_q;
    err_d     = err_q;
    data_d    = data_q;
    vld_d[0]  = accept;
    we_d[0]   = accept && req_we_i;
    err_d[0]  = accept && !in_range;
    data_d[0] = s0_data;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      we_d[i]   = we_q[i-1];
      err_d[i]  = err_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_q <= '0;
      we_q  <= '0;
      err_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else if (advance) begin
      vld_q  <= vld_d;
      we_q   <= we_d;
      err_q  <= err_d;
      data_q <= data_d;
    end
  end

  assign req_ready_o       = advance;
  assign rsp_valid_o       = vld_q[LATENCY-1];
  assign rsp_we_o          = we_q[LATENCY-1];
  assign rsp_err_o         = err_q[LATENCY-1];
  assign rsp_rdata_o       = data_q[LATENCY-1];
  assign busy_o            = |vld_q;
  assign dbg_stage_valid_o = vld_q;

endmodule
